load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the core's execute stage and the word-only data memory.
//  Converts byte/half/word load and store requests (RISC-V funct3 encoding)
//  into aligned 32-bit memory accesses.
//  - Sub-word loads: extracts the lane and sign/zero-extends it.
//  - Sub-word stores: read-modify-write sequence.
//  - Misaligned or illegal requests: flagged, no memory access.
// PARAMETERS
//  ADDR_W  32  byte-address width; only 32 supported
//  DATA_W  32  data width; only 32 supported
// PORTS
//  clk         in   1   clock
//  reset       in   1   reset, synchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   LSU can accept a request (IDLE only)
//  req_write   in   1   1=store, 0=load
//  req_funct3  in   3   000 b, 001 h, 010 w, 100 bu, 101 hu
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data; low byte/half used for sb/sh
//  rsp_valid   out  1   one-cycle completion pulse
//  rsp_rdata   out  32  extended load data; 0 for stores and errors
//  rsp_err     out  1   misaligned or illegal funct3; valid with rsp_valid
//  mem_addr    out  32  word address {addr[31:2],2'b00}
//  mem_din     out  32  write word to memory
//  mem_read    out  1   async read enable
//  mem_write   out  1   write enable; memory commits at the next posedge
//  mem_dout    in   32  async read data, valid in the same cycle as mem_read
// BEHAVIOUR
//  FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
//  Reset: state=IDLE; all latched registers, rsp_*, mem_* = 0.
//  - reset dominates any state.
//  - mem_write is forced 0 in any cycle where reset=1, so a store is
//    never committed once reset asserts mid-operation.
//  Handshake and latching:
//  - req_ready=1 only in IDLE; accept = req_valid & req_ready.
//  - On accept, latch write, funct3, addr, wdata.
//  - No response backpressure.
//  - No new accept in RESP; the next accept is the cycle after RESP.
//  IDLE -> RESP with err=1, no mem access, when any of:
//  - funct3 illegal (011, 110, 111, or 100/101 with write=1)
//  - half access with addr[0]=1
//  - word access with addr[1:0]!=0
//  Otherwise from IDLE:
//  - load -> LOAD
//  - sw -> WRITE
//  - sb/sh -> RMW_RD
//  LOAD: mem_read=1; lane = mem_dout >> (8*addr[1:0]).
//  - b: sign-extend bit 7;  bu: zero-extend.
//  - h: sign-extend bit 15; hu: zero-extend.
//  - w: pass through.
//  - Register result; -> RESP.
//  RMW_RD: mem_read=1; merge into a registered word:
//  - sb: replace byte lane addr[1:0] with wdata[7:0].
//  - sh: replace half lane addr[1] with wdata[15:0].
//  - -> WRITE.
//  WRITE: mem_write=1; mem_din = merged word (sb/sh) or wdata (sw); -> RESP.
//  RESP: rsp_valid=1 for exactly one cycle; -> IDLE.
//  Idle memory outputs: mem_read=mem_write=0 outside LOAD/RMW_RD/WRITE.
//  - mem_addr holds the latched word address.
//  Latency (accept at cycle t) to rsp_valid:
//  - error: t+1
//  - load or sw: t+2
//  - sb/sh: t+3
// CONFIGURATION
//  LSU_PERF_CNT_EN defined: adds outputs
//  - perf_loads, perf_stores, perf_errs, each 32 bits.
//  - Each increments in its RESP cycle by request type (error takes
//    priority); wraps at 2^32; cleared by reset.
//  LSU_PERF_CNT_EN undefined: no counter ports or logic; otherwise identical.
// TESTING
//  1. Mem word@0x40=0x8899AABB; lb 0x41 -> rsp_rdata=0xFFFFFFAA at t+2;
//     lbu 0x41 -> 0x000000AA; lhu 0x42 -> 0x00008899; lh 0x42 -> 0xFFFF8899.
//  2. Word@0x40=0x11223344; sb 0x43 wdata=0xAB -> one mem_read, then
//     mem_write with mem_din=0xAB223344; rsp_valid at t+3; then
//     sh 0x40 wdata=0xBEEF -> 0xAB22BEEF.
//  3. sw 0x44 0xDEADBEEF -> mem_write 1 cycle, mem_addr=0x44; lw 0x44 ->
//     0xDEADBEEF; req_ready=0 from t+1 until the cycle after RESP.
//  4. lw 0x46, sh 0x41, and funct3=011 -> rsp_err=1, rsp_rdata=0 at t+1;
//     mem_read and mem_write never asserted.
//  5. Accept sb, then assert reset in the RMW_RD cycle -> mem_write never
//     asserted, memory unchanged, all outputs 0, next cycle req_ready=1.
//  6. With LSU_PERF_CNT_EN: 2 loads, 1 store, 1 error ->
//     perf_loads=2, perf_stores=1, perf_errs=1; reset clears all to 0.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: bridges the execute stage to a word-only data memory.
// Byte/half/word loads and stores (RISC-V funct3 encoding) become aligned
// 32-bit accesses. Sub-word loads are lane-extracted and sign/zero-extended.
// Sub-word stores use a read-modify-write. Misaligned or illegal requests
// are answered with rsp_err and make no memory access.
// Optional feature macro: LSU_PERF_CNT_EN adds the perf_loads, perf_stores
// and perf_errs completion counters.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_dout
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_errs
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t            state_r;
    logic [2:0]        funct3_r;
    logic [1:0]        lane_r;
    logic [DATA_W-1:0] wdata_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_din_r;
    logic              mem_read_r;
    logic              mem_write_r;
`ifdef LSU_PERF_CNT_EN
    logic              write_r;
`endif

    logic              accept_s;
    logic              req_bad_s;

    // A request is bad when funct3 is not a legal encoding for its
    // direction or when the address is not aligned to the access size.
    function automatic logic req_is_bad(input logic wr, input logic [2:0] f3,
                                        input logic [1:0] a);
        logic bad;
        case (f3)
            3'b000:         bad = 1'b0;
            3'b001:         bad = a[0];
            3'b010:         bad = (a != 2'b00);
            3'b100, 3'b101: bad = wr | (f3[0] & a[0]);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Select the addressed lane of a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                                input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b100:  res = {24'h000000, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b101:  res = {16'h0000, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Overlay the store data onto the old memory word at the addressed lane.
    function automatic logic [31:0] store_merge(input logic [1:0] size,
                                                input logic [1:0] lane,
                                                input logic [31:0] old_word,
                                                input logic [31:0] wd);
        logic [31:0] m;
        m = old_word;
        case (size)
            2'b00:   m[{lane, 3'b000} +: 8]     = wd[7:0];
            2'b01:   m[{lane[1], 4'b0000} +: 16] = wd[15:0];
            default: m = wd;
        endcase
        return m;
    endfunction

    // Acceptance and request legality, decoded straight from the inputs.
    always_comb begin
        accept_s  = req_valid & (state_r == S_IDLE);
        req_bad_s = req_is_bad(req_write, req_funct3, req_addr[1:0]);
    end

    assign req_ready = (state_r == S_IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign mem_addr  = mem_addr_r;
    assign mem_din   = mem_din_r;
    assign mem_read  = mem_read_r;
    // The write strobe is cut by reset in the same cycle, so an in-flight
    // store can never be committed once reset is raised.
    assign mem_write = mem_write_r & ~reset;

    // Main sequencer: state, latched request fields and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            funct3_r    <= 3'b000;
            lane_r      <= 2'b00;
            wdata_r     <= '0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
            mem_addr_r  <= '0;
            mem_din_r   <= '0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
`ifdef LSU_PERF_CNT_EN
            write_r     <= 1'b0;
`endif
        end else begin
            rsp_valid_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        funct3_r   <= req_funct3;
                        lane_r     <= req_addr[1:0];
                        wdata_r    <= req_wdata;
                        mem_addr_r <= {req_addr[ADDR_W-1:2], 2'b00};
`ifdef LSU_PERF_CNT_EN
                        write_r    <= req_write;
`endif
                        if (req_bad_s) begin
                            state_r     <= S_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= '0;
                        end else if (!req_write) begin
                            state_r    <= S_LOAD;
                            mem_read_r <= 1'b1;
                        end else if (req_funct3[1:0] == 2'b10) begin
                            state_r     <= S_WRITE;
                            mem_write_r <= 1'b1;
                            mem_din_r   <= req_wdata;
                        end else begin
                            state_r    <= S_RMW_RD;
                            mem_read_r <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    rsp_rdata_r <= load_extend(funct3_r, lane_r, mem_dout);
                    rsp_err_r   <= 1'b0;
                    rsp_valid_r <= 1'b1;
                    state_r     <= S_RESP;
                end
                S_RMW_RD: begin
                    mem_din_r   <= store_merge(funct3_r[1:0], lane_r, mem_dout, wdata_r);
                    mem_write_r <= 1'b1;
                    state_r     <= S_WRITE;
                end
                S_WRITE: begin
                    rsp_rdata_r <= '0;
                    rsp_err_r   <= 1'b0;
                    rsp_valid_r <= 1'b1;
                    state_r     <= S_RESP;
                end
                S_RESP: begin
                    rsp_rdata_r <= '0;
                    rsp_err_r   <= 1'b0;
                    state_r     <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LSU_PERF_CNT_EN
    // Completion counters, bumped once per request in its response cycle;
    // an error is counted as an error regardless of direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_loads  <= 32'd0;
            perf_stores <= 32'd0;
            perf_errs   <= 32'd0;
        end else if (state_r == S_RESP) begin
            if (rsp_err_r) begin
                perf_errs <= perf_errs + 32'd1;
            end else if (write_r) begin
                perf_stores <= perf_stores + 32'd1;
            end else begin
                perf_loads <= perf_loads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by
// randomized requests checked against a byte-array reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_dout;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;
    logic [31:0] perf_errs;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Memory attached to the DUT (256 bytes) and the bench's own byte model.
    logic [31:0] dmem [0:63];
    logic [7:0]  ref_bytes [0:255];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'd0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
        .mem_write(mem_write), .mem_dout(mem_dout)
`ifdef LSU_PERF_CNT_EN
        , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_errs(perf_errs)
`endif
    );

    assign mem_dout = dmem[mem_addr[7:2]];

    // Word memory: commits DUT writes at the edge, bench preloads otherwise.
    always @(posedge clk) begin
        if (mem_write) dmem[mem_addr[7:2]] <= mem_din;
        else if (pl_en) dmem[pl_idx] <= pl_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a - (a % 4);
        return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
    endfunction

    task automatic set_word(input int a, input logic [31:0] v);
        int b;
        b = a - (a % 4);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = 6'(b / 4); pl_data = v;
        for (int k = 0; k < 4; k++) ref_bytes[b+k] = v[8*k +: 8];
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive_req(input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        check_eq("ready_before_accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // One transaction, scored against the specification's rules.
    task automatic do_req(input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        int size, exp_lat, exp_reads, exp_writes, reads, writes, lat, a;
        logic exp_err, got, er;
        logic [31:0] exp_rd, rd, wa;
        longint v;
        a = int'(addr);
        size = 1 << f3[1:0];
        exp_err = wr ? !(f3 inside {3'b000, 3'b001, 3'b010})
                     : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        if (!exp_err && (a % size) != 0) exp_err = 1'b1;
        wa = addr - (addr % 4);
        exp_rd = 32'd0;
        if (!exp_err && !wr) begin
            v = 0;
            for (int k = 0; k < size; k++) v = v | (longint'(ref_bytes[a+k]) << (8*k));
            if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size-1)))
                v = v - (longint'(1) << (8*size));
            exp_rd = v[31:0];
        end
        exp_lat    = exp_err ? 1 : ((!wr || size == 4) ? 2 : 3);
        exp_reads  = (!exp_err && (!wr || size < 4)) ? 1 : 0;
        exp_writes = (!exp_err && wr) ? 1 : 0;

        drive_req(wr, f3, addr, wd);
        reads = 0; writes = 0; lat = 0; got = 1'b0; rd = 32'd0; er = 1'b0;
        for (int cyc = 1; cyc <= 8 && !got; cyc++) begin
            @(negedge clk);
            if (mem_read)  begin reads++;  check_eq("rd_addr", mem_addr, wa); end
            if (mem_write) begin writes++; check_eq("wr_addr", mem_addr, wa); end
            if (rsp_valid) begin got = 1'b1; lat = cyc; rd = rsp_rdata; er = rsp_err; end
            else check_eq("ready_busy", {31'd0, req_ready}, 32'd0);
        end
        if (!got) check_eq("rsp_timeout", 32'd0, 32'd1);
        check_eq("latency", lat, exp_lat);
        check_eq("rsp_rdata", rd, exp_rd);
        check_eq("rsp_err", {31'd0, er}, {31'd0, exp_err});
        check_eq("mem_reads", reads, exp_reads);
        check_eq("mem_writes", writes, exp_writes);
        @(negedge clk);
        check_eq("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        check_eq("ready_after", {31'd0, req_ready}, 32'd1);
        if (wr && !exp_err)
            for (int k = 0; k < size; k++) ref_bytes[a+k] = wd[8*k +: 8];
        check_eq("mem_word", dmem[wa[7:2]], ref_word(a));
    endtask

    logic [31:0] saved;
    logic        wr_r;
    logic [2:0]  f3_r;
    logic [31:0] ad_r;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // Reset state of every output.
        check_eq("reset_ready", {31'd0, req_ready}, 32'd1);
        check_eq("reset_outs", {28'd0, rsp_valid, rsp_err, mem_read, mem_write}, 32'd0);
        check_eq("reset_rdata", rsp_rdata, 32'd0);
        check_eq("reset_maddr", mem_addr, 32'd0);
        check_eq("reset_mdin", mem_din, 32'd0);

        for (int i = 0; i < 64; i++) set_word(4*i, $urandom);

        // Sub-word loads with sign and zero extension.
        set_word(32'h40, 32'h8899AABB);
        do_req(1'b0, 3'b000, 32'h41, 32'd0);
        do_req(1'b0, 3'b100, 32'h41, 32'd0);
        do_req(1'b0, 3'b101, 32'h42, 32'd0);
        do_req(1'b0, 3'b001, 32'h42, 32'd0);
        // Read-modify-write byte and half stores.
        set_word(32'h40, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h43, 32'h000000AB);
        check_eq("sb_word", dmem[16], 32'hAB223344);
        do_req(1'b1, 3'b001, 32'h40, 32'h0000BEEF);
        check_eq("sh_word", dmem[16], 32'hAB22BEEF);
        // Full word store then load.
        do_req(1'b1, 3'b010, 32'h44, 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h44, 32'd0);
        // Error cases.
        do_req(1'b0, 3'b010, 32'h46, 32'd0);
        do_req(1'b1, 3'b001, 32'h41, 32'h1234);
        do_req(1'b0, 3'b011, 32'h40, 32'd0);
        do_req(1'b1, 3'b100, 32'h40, 32'd0);

        // Reset during the read half of a byte store: nothing is written.
        saved = dmem[16];
        drive_req(1'b1, 3'b000, 32'h42, 32'h0000005A);
        @(negedge clk);
        check_eq("rmw_read_seen", {31'd0, mem_read}, 32'd1);
        reset = 1'b1;
        #1 check_eq("rst_rmw_nowrite", {31'd0, mem_write}, 32'd0);
        @(posedge clk);
        #1 check_eq("rst_rmw_nowrite2", {31'd0, mem_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_rmw_outs", {28'd0, rsp_valid, rsp_err, mem_read, mem_write}, 32'd0);
        check_eq("rst_rmw_mdin", mem_din, 32'd0);
        check_eq("rst_rmw_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        check_eq("rst_rmw_nowrite3", {31'd0, mem_write}, 32'd0);
        check_eq("rst_rmw_mem", dmem[16], saved);

        // Reset raised in the write cycle itself: the strobe drops at once.
        saved = dmem[17];
        drive_req(1'b1, 3'b010, 32'h44, 32'h0BADF00D);
        @(negedge clk);
        check_eq("wr_cycle_seen", {31'd0, mem_write}, 32'd1);
        reset = 1'b1;
        #1 check_eq("rst_wr_gate", {31'd0, mem_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_wr_mem", dmem[17], saved);
        check_eq("rst_wr_ready", {31'd0, req_ready}, 32'd1);

        // Randomized traffic; addresses are aligned to the access size half
        // the time so that legal accesses dominate.
        for (int n = 0; n < 300; n++) begin
            wr_r = 1'($urandom_range(0, 1));
            f3_r = 3'($urandom_range(0, 7));
            ad_r = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0 && f3_r[1:0] != 2'b11)
                ad_r = ad_r & ~((32'd1 << f3_r[1:0]) - 32'd1);
            do_req(wr_r, f3_r, ad_r, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

`ifdef LSU_PERF_CNT_EN
        apply_reset();
        check_eq("perf_clr_l", perf_loads, 32'd0);
        do_req(1'b0, 3'b010, 32'h40, 32'd0);
        do_req(1'b0, 3'b100, 32'h41, 32'd0);
        do_req(1'b1, 3'b000, 32'h45, 32'h77);
        do_req(1'b0, 3'b001, 32'h43, 32'd0);
        check_eq("perf_loads", perf_loads, 32'd2);
        check_eq("perf_stores", perf_stores, 32'd1);
        check_eq("perf_errs", perf_errs, 32'd1);
        apply_reset();
        check_eq("perf_rst_l", perf_loads, 32'd0);
        check_eq("perf_rst_s", perf_stores, 32'd0);
        check_eq("perf_rst_e", perf_errs, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
